dc_useq: RTL and testbench

Microsequencer for the DC303 microcode ROM: drives the 10-bit ROM address (AX bit plus 9-bit micro-PC) and consumes the ROM's 9-bit next-address and 16-bit microcode outputs. Registers the fetched microinstruction into a pipeline register (MIR) for the datapath and control chips. Selects the next micro-PC from the ROM link field, an external jump/trap vector, or a small return stack. Sits between the instruction-decode/trap logic and the DC303 ROM, one instance per ROM.

---
 rtl/dc_useq_if.sv | 27 ++
 rtl/dc_useq.sv | 106 ++++++++++
 tb/tb_dc_useq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dc_useq_if.sv
// Signal bundle between the DC303 microsequencer, its microcode ROM and the
// decode/trap logic that issues jump, call and return requests.
interface dc_useq_if;
  logic        stall;
  logic        ax;
  logic        jmp_req;
  logic [8:0]  jmp_addr;
  logic        call_req;
  logic        ret_req;
  logic [8:0]  ma_in;
  logic [15:0] mc_in;
  logic [9:0]  a_out;
  logic [8:0]  upc;
  logic [15:0] mir;
  logic        mir_vld;
  logic        stk_err;

  modport master (
    input  stall, ax, jmp_req, jmp_addr, call_req, ret_req, ma_in, mc_in,
    output a_out, upc, mir, mir_vld, stk_err
  );

  modport slave (
    output stall, ax, jmp_req, jmp_addr, call_req, ret_req, ma_in, mc_in,
    input  a_out, upc, mir, mir_vld, stk_err
  );
endinterface

// File: rtl/dc_useq.sv
// DC303 microsequencer: addresses the microcode ROM, latches the fetched word
// into the MIR, and picks the next micro-PC from link field, jump or return stack.
module dc_useq #(
  parameter logic [8:0] RESET_ADDR = 9'h000,
  parameter int         STK_DEPTH  = 4
) (
  input  logic      clk,
  input  logic      nrst,
  dc_useq_if.master bus
);

  localparam int SPW = $clog2(STK_DEPTH + 1);
  localparam int IW  = $clog2(STK_DEPTH);

  logic [8:0]     upc_q, upc_d;
  logic           ax_q, ax_d;
  logic [15:0]    mir_q, mir_d;
  logic           mir_vld_q, mir_vld_d;
  logic           stk_err_q, stk_err_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [8:0]     stk_q [STK_DEPTH];
  logic [8:0]     stk_d [STK_DEPTH];

  logic           stk_full;
  logic           stk_empty;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  pop_idx;

  assign stk_full  = (sp_q == SPW'(STK_DEPTH));
  assign stk_empty = (sp_q == '0);
  // Index wraps when full/empty, but those cases never touch the array.
  assign push_idx  = IW'(sp_q);
  assign pop_idx   = IW'(sp_q - SPW'(1));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would infer a latch.
    upc_d     = upc_q;
    ax_d      = ax_q;
    mir_d     = mir_q;
    mir_vld_d = mir_vld_q;
    stk_err_d = stk_err_q;
    sp_d      = sp_q;
    stk_d     = stk_q;

    if (!bus.stall) begin
      mir_d     = bus.mc_in;
      mir_vld_d = 1'b1;
      ax_d      = bus.ax;

      if (bus.jmp_req) begin
        upc_d = bus.jmp_addr;
        if (bus.call_req) begin
          // The ROM link field of the calling word is the return point.
          if (stk_full) begin
            stk_err_d = 1'b1;
          end else begin
            stk_d[push_idx] = bus.ma_in;
            sp_d            = sp_q + SPW'(1);
          end
        end
      end else if (bus.ret_req) begin
        if (stk_empty) begin
          upc_d     = RESET_ADDR;
          stk_err_d = 1'b1;
        end else begin
          upc_d = stk_q[pop_idx];
          sp_d  = sp_q - SPW'(1);
        end
      end else begin
        upc_d = bus.ma_in;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      upc_q     <= RESET_ADDR;
      ax_q      <= 1'b0;
      mir_q     <= '0;
      mir_vld_q <= 1'b0;
      stk_err_q <= 1'b0;
      sp_q      <= '0;
      // NOTE: the return stack is only a few flops, so it is cleared on reset
      // like any other state; a large RAM-style array would not be.
      for (int i = 0; i < STK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      upc_q     <= upc_d;
      ax_q      <= ax_d;
      mir_q     <= mir_d;
      mir_vld_q <= mir_vld_d;
      stk_err_q <= stk_err_d;
      sp_q      <= sp_d;
      stk_q     <= stk_d;
    end
  end

  assign bus.a_out   = {ax_q, upc_q};
  assign bus.upc     = upc_q;
  assign bus.mir     = mir_q;
  assign bus.mir_vld = mir_vld_q;
  assign bus.stk_err = stk_err_q;

endmodule

// File: tb/tb_dc_useq.sv
// Scoreboard bench for dc_useq: a combinational ROM model (link = addr+1,
// word = {6'h2B, addr}) and directed sequences with hand-computed micro-PCs.
module tb_dc_useq;

  localparam logic [8:0] RST_ADDR = 9'h000;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  dc_useq_if bus ();

  dc_useq #(.RESET_ADDR(RST_ADDR), .STK_DEPTH(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  assign bus.ma_in = bus.a_out[8:0] + 9'd1;
  assign bus.mc_in = {6'h2B, bus.a_out};

  typedef struct packed {
    logic [8:0]  upc;
    logic [9:0]  a;
    logic [15:0] mir;
    logic        vld;
    logic        err;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  obs_t  cur;
  int    n_vec = 0;
  int    n_err = 0;
  logic  mon_tick = 1'b0;

  // Monitor: compares DUT outputs against the oldest expectation.
  always @(negedge clk or posedge mon_tick) begin
    obs_t  e;
    obs_t  got;
    string nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {bus.upc, bus.a_out, bus.mir, bus.mir_vld, bus.stk_err};
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL %s: got upc=%h a_out=%h mir=%h vld=%b err=%b, want upc=%h a_out=%h mir=%h vld=%b err=%b",
                 nm, got.upc, got.a, got.mir, got.vld, got.err,
                 e.upc, e.a, e.mir, e.vld, e.err);
      end
    end
  end

  task automatic check(input logic ok, input string nm);
    n_vec++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL %s", nm);
    end
  endtask

  task automatic push_exp(input string nm);
    exp_q.push_back(cur);
    name_q.push_back(nm);
  endtask

  task automatic set_reset_state();
    cur     = '0;
    cur.upc = RST_ADDR;
    cur.a   = {1'b0, RST_ADDR};
  endtask

  task automatic rst_cyc(input string nm);
    nrst = 1'b0;
    @(posedge clk);
    set_reset_state();
    push_exp(nm);
    @(negedge clk);
  endtask

  task automatic drive(input logic st, input logic ax_i, input logic jmp,
                       input logic call, input logic ret, input logic [8:0] ja,
                       input logic [8:0] exp_upc, input logic exp_err,
                       input string nm);
    bus.stall    = st;
    bus.ax       = ax_i;
    bus.jmp_req  = jmp;
    bus.call_req = call;
    bus.ret_req  = ret;
    bus.jmp_addr = ja;
    @(posedge clk);
    if (!st) begin
      cur.mir = {6'h2B, cur.a};
      cur.vld = 1'b1;
      cur.upc = exp_upc;
      cur.a   = {ax_i, exp_upc};
    end
    cur.err = exp_err;
    push_exp(nm);
    @(negedge clk);
  endtask

  task automatic nxt(input logic [8:0] e, input logic er, input string nm);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, e, er, nm);
  endtask
  task automatic jp(input logic [8:0] ja, input logic [8:0] e, input logic er, input string nm);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ja, e, er, nm);
  endtask
  task automatic cl(input logic [8:0] ja, input logic [8:0] e, input logic er, input string nm);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ja, e, er, nm);
  endtask
  task automatic rt(input logic [8:0] e, input logic er, input string nm);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h0, e, er, nm);
  endtask

  initial begin
    bus.stall    = 1'b0;
    bus.ax       = 1'b0;
    bus.jmp_req  = 1'b0;
    bus.call_req = 1'b0;
    bus.ret_req  = 1'b0;
    bus.jmp_addr = 9'h0;
    set_reset_state();

    rst_cyc("reset0");
    rst_cyc("reset1");
    nrst = 1'b1;

    // Linear fetch: link field is addr+1
    nxt(9'h001, 1'b0, "lin1");
    nxt(9'h002, 1'b0, "lin2");
    nxt(9'h003, 1'b0, "lin3");
    nxt(9'h004, 1'b0, "lin4");
    nxt(9'h005, 1'b0, "lin5");

    // Stall with a jump request pending: everything holds
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h1FF, 9'h005, 1'b0, "stall1");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h1FF, 9'h005, 1'b0, "stall2");
    nxt(9'h006, 1'b0, "resume");

    // Call / return
    jp(9'h010, 9'h010, 1'b0, "jump010");
    cl(9'h100, 9'h100, 1'b0, "call100");
    nxt(9'h101, 1'b0, "in_sub");
    rt(9'h011, 1'b0, "ret011");
    nxt(9'h012, 1'b0, "after_ret");

    // AX select, then priority rules
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 9'h013, 1'b0, "ax_set");
    nxt(9'h014, 1'b0, "ax_clr");
    cl(9'h050, 9'h050, 1'b0, "pri_call");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h060, 9'h060, 1'b0, "pri_jmp_ret");
    rt(9'h015, 1'b0, "pri_ret");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h0AA, 9'h016, 1'b0, "call_alone");

    // Overflow: pushes 017,101,111,121; fifth push dropped
    cl(9'h100, 9'h100, 1'b0, "ovf_c1");
    cl(9'h110, 9'h110, 1'b0, "ovf_c2");
    cl(9'h120, 9'h120, 1'b0, "ovf_c3");
    cl(9'h130, 9'h130, 1'b0, "ovf_c4");
    cl(9'h140, 9'h140, 1'b1, "ovf_c5");
    rt(9'h121, 1'b1, "lifo1");
    rt(9'h111, 1'b1, "lifo2");
    rt(9'h101, 1'b1, "lifo3");
    rt(9'h017, 1'b1, "lifo4");
    rt(RST_ADDR, 1'b1, "underflow");

    // Async reset pulse between edges with two stack entries
    cl(9'h080, 9'h080, 1'b1, "pre_rst_c1");
    cl(9'h090, 9'h090, 1'b1, "pre_rst_c2");
    #2 nrst = 1'b0;
    #1;
    set_reset_state();
    push_exp("async_rst");
    mon_tick = 1'b1;
    #1 nrst = 1'b1;
    mon_tick = 1'b0;
    rt(RST_ADDR, 1'b1, "ret_after_rst");
    nxt(9'h001, 1'b1, "err_sticky");

    rst_cyc("final_rst");

    check(bus.upc === RST_ADDR, "final_rst upc");
    check(bus.a_out === {1'b0, RST_ADDR}, "final_rst a_out");
    check(bus.mir === 16'h0000, "final_rst mir");
    check(bus.mir_vld === 1'b0, "final_rst mir_vld");
    check(bus.stk_err === 1'b0, "final_rst stk_err");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    while (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL %s: got no comparison, want one within 20 cycles", name_q.pop_front());
      void'(exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
